// File: rtl/nibble_serial_add_ctrl_if.sv
// Operand/result handshake bundle for the slice-serial adder.
// The master side issues operands and consumes results; the slave side is the adder.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             Co;
    logic             Ovf;

    modport master (
        output in_valid, A, B, Ci, sub, out_ready,
        input  in_ready, out_valid, S, Co, Ovf
    );

    modport slave (
        input  in_valid, A, B, Ci, sub, out_ready,
        output in_ready, out_valid, S, Co, Ovf
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// WIDTH-bit add/subtract computed one SLICE-bit slice per clock on a single shared slice adder.
// Operands are accepted in IDLE, rippled through RUN, and the result is held in DONE until taken.
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDX_W-1:0] idx;
    logic             carry;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_nxt;
    logic [SLICE:0]   slice_sum;
    logic             accept;
    logic             last;
    logic             ovf_nxt;
    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;

    // Zero-extended slice add; the MSB of the return value is the slice carry-out.
    function automatic logic [SLICE:0] slice_add(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             ci);
        return {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, ci};
    endfunction

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last      = (idx == LAST_IDX);
        slice_sum = slice_add(op_a[idx*SLICE +: SLICE], op_b[idx*SLICE +: SLICE], carry);
        res_nxt   = res;
        res_nxt[idx*SLICE +: SLICE] = slice_sum[SLICE-1:0];
        ovf_nxt   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (res_nxt[WIDTH-1] != op_a[WIDTH-1]);
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control, carry and visible result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            s_q   <= '0;
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                idx   <= '0;
                carry <= bus.sub ? 1'b1 : bus.Ci;
            end else if (state == RUN) begin
                carry <= slice_sum[SLICE];
                if (last) begin
                    s_q   <= res_nxt;
                    co_q  <= slice_sum[SLICE];
                    ovf_q <= ovf_nxt;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Operand and partial-result storage; only meaningful once an operation is accepted.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_a <= bus.A;
            op_b <= bus.sub ? ~bus.B : bus.B;
        end else if (state == RUN) begin
            res <= res_nxt;
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.S         = s_q;
    assign bus.Co        = co_q;
    assign bus.Ovf       = ovf_q;
endmodule
